// File: rtl/mem_access_unit_pkg.sv
// Shared memory-op codes, FSM encodings and access-size decode for the MEM-stage access unit.
package mem_access_unit_pkg;

    localparam int unsigned MEMOP_W = 7;

    // Memory operation codes carried down the pipeline with each instruction
    localparam logic [MEMOP_W-1:0] tMEM_OP_NULL   = 7'd0;
    localparam logic [MEMOP_W-1:0] tMEM_OP_BYTE   = 7'd1;
    localparam logic [MEMOP_W-1:0] tMEM_OP_BYTEU  = 7'd2;
    localparam logic [MEMOP_W-1:0] tMEM_OP_HWORD  = 7'd3;
    localparam logic [MEMOP_W-1:0] tMEM_OP_HWORDU = 7'd4;
    localparam logic [MEMOP_W-1:0] tMEM_OP_WORD   = 7'd5;

    // Access FSM encodings
    localparam logic [1:0] MEM_ST_IDLE = 2'd0;
    localparam logic [1:0] MEM_ST_REQ  = 2'd1;
    localparam logic [1:0] MEM_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    typedef struct packed {
        acc_size_e size;
        logic      sext;
    } op_dec_t;

    // NULL and unknown codes behave as a full word access
    function automatic op_dec_t decode_op(input logic [MEMOP_W-1:0] op);
        op_dec_t d;
        d.size = SZ_WORD;
        d.sext = 1'b0;
        case (op)
            tMEM_OP_BYTE:   begin d.size = SZ_BYTE; d.sext = 1'b1; end
            tMEM_OP_BYTEU:  begin d.size = SZ_BYTE; d.sext = 1'b0; end
            tMEM_OP_HWORD:  begin d.size = SZ_HALF; d.sext = 1'b1; end
            tMEM_OP_HWORDU: begin d.size = SZ_HALF; d.sext = 1'b0; end
            default:        begin d.size = SZ_WORD; d.sext = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane aligner: load extract/extend, store replication,
// byte-enable generation and misalignment detection.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [MEMOP_W-1:0]         memop_type,
    input  logic                       is_store,
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
    input  logic [31:0]                st_data,
    input  logic [DATA_W-1:0]          ld_bus,
    output logic [31:0]                ld_result,
    output logic [DATA_W-1:0]          st_bus,
    output logic [DATA_W/8-1:0]        bwe,
    output logic                       misalign
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(LANES);
    localparam int unsigned HALVES = LANES / 2;
    localparam int unsigned WORDS  = LANES / 4;

    op_dec_t          dec;
    logic [OFS_W-1:0] word_ofs;
    logic [OFS_W-1:0] half_ofs;
    logic [31:0]      ld_word;
    logic [15:0]      ld_half;
    logic [7:0]       ld_byte;

    // Lane steering: pick the 32-bit word first, then the byte/half inside it
    always_comb begin
        dec       = decode_op(memop_type);
        word_ofs  = addr_lo & ~OFS_W'(3);
        half_ofs  = addr_lo & ~OFS_W'(1);
        ld_word   = 32'(ld_bus >> {word_ofs, 3'b000});
        ld_half   = 16'(ld_word >> {addr_lo[1], 4'b0000});
        ld_byte   = 8'(ld_word >> {addr_lo[1:0], 3'b000});
        ld_result = ld_word;
        st_bus    = '0;
        bwe       = '0;
        misalign  = 1'b0;
        case (dec.size)
            SZ_BYTE: begin
                ld_result = {{24{dec.sext & ld_byte[7]}}, ld_byte};
                st_bus    = {LANES{st_data[7:0]}};
                bwe       = LANES'(1) << addr_lo;
                misalign  = 1'b0;
            end
            SZ_HALF: begin
                ld_result = {{16{dec.sext & ld_half[15]}}, ld_half};
                st_bus    = {HALVES{st_data[15:0]}};
                bwe       = LANES'(2'b11) << half_ofs;
                misalign  = addr_lo[0];
            end
            default: begin
                ld_result = ld_word;
                st_bus    = {WORDS{st_data}};
                bwe       = LANES'(4'hF) << word_ofs;
                misalign  = |addr_lo[1:0];
            end
        endcase
        if (!is_store) begin
            bwe = '0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues loads/stores over a req/ack SRAM handshake,
// stalls the pipeline while outstanding and flags address/bus errors.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_memop_in,
    input  logic                  MEM_memwr_in,
    input  logic [MEMOP_W-1:0]    MEM_memop_type_in,
    input  logic [31:0]           MEM_ALUOut_in,
    input  logic [31:0]           MEM_STData_in,
    input  logic [4:0]            MEM_inst_rd_in,
    input  logic                  MEM_RegWrite_in,
    input  logic                  MEM_ack_in,
    input  logic [DATA_W-1:0]     MEM_LDData_in,
    output logic                  MEM_req_out,
    output logic [31:0]           MEM_Addr_out,
    output logic                  MEM_memwr_out,
    output logic [DATA_W/8-1:0]   MEM_bwe_out,
    output logic [DATA_W-1:0]     MEM_STData_out,
    output logic                  MEM_stall_out,
    output logic [31:0]           MEM_MUXOut_out,
    output logic [4:0]            MEM_inst_rd_out,
    output logic                  MEM_RegWrite_out,
    output logic                  MEM_adel_out,
    output logic                  MEM_ades_out,
    output logic                  MEM_buserr_out
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(LANES);
    localparam bit          TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CNT_W-1:0]  cnt;
    logic              err_flag;
    logic [31:0]       ld_reg;
    logic              start;
    logic              acked;
    logic              timed_out;

    logic [31:0]       al_ld;
    logic [DATA_W-1:0] al_st;
    logic [LANES-1:0]  al_bwe;
    logic              al_mis;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .memop_type (MEM_memop_type_in),
        .is_store   (MEM_memwr_in),
        .addr_lo    (MEM_ALUOut_in[OFS_W-1:0]),
        .st_data    (MEM_STData_in),
        .ld_bus     (MEM_LDData_in),
        .ld_result  (al_ld),
        .st_bus     (al_st),
        .bwe        (al_bwe),
        .misalign   (al_mis)
    );

    assign MEM_inst_rd_out = MEM_inst_rd_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the combinational stall/result/error outputs
    always_comb begin
        next_state       = state;
        start            = 1'b0;
        acked            = 1'b0;
        timed_out        = 1'b0;
        MEM_stall_out    = 1'b0;
        MEM_MUXOut_out   = MEM_ALUOut_in;
        MEM_RegWrite_out = MEM_RegWrite_in;
        MEM_adel_out     = 1'b0;
        MEM_ades_out     = 1'b0;
        MEM_buserr_out   = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                if (MEM_memop_in) begin
                    MEM_RegWrite_out = 1'b0;
                    if (al_mis) begin
                        MEM_adel_out = !MEM_memwr_in;
                        MEM_ades_out = MEM_memwr_in;
                    end else begin
                        MEM_stall_out = 1'b1;
                        start         = 1'b1;
                        next_state    = MEM_ST_REQ;
                    end
                end
            end
            MEM_ST_REQ: begin
                MEM_stall_out    = 1'b1;
                MEM_RegWrite_out = 1'b0;
                if (MEM_ack_in) begin
                    acked      = 1'b1;
                    next_state = MEM_ST_DONE;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    timed_out  = 1'b1;
                    next_state = MEM_ST_DONE;
                end
            end
            MEM_ST_DONE: begin
                next_state     = MEM_ST_IDLE;
                MEM_buserr_out = err_flag;
                if (err_flag) begin
                    MEM_MUXOut_out   = 32'd0;
                    MEM_RegWrite_out = 1'b0;
                end else if (!MEM_memwr_in) begin
                    MEM_MUXOut_out = ld_reg;
                end
            end
            default: begin
                next_state = MEM_ST_IDLE;
            end
        endcase
        // Reset drops the stall at once even while the held op is still presented
        if (rst) begin
            MEM_stall_out = 1'b0;
            MEM_adel_out  = 1'b0;
            MEM_ades_out  = 1'b0;
        end
    end

    // Timeout counter and bus-error flag, both cleared on the way back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            err_flag <= 1'b0;
        end else if (state == MEM_ST_REQ) begin
            cnt <= cnt + CNT_W'(1);
            if (timed_out) begin
                err_flag <= 1'b1;
            end
        end else if (state == MEM_ST_DONE) begin
            cnt      <= '0;
            err_flag <= 1'b0;
        end
    end

    // Capture the aligned load result on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_reg <= '0;
        end else if (acked) begin
            ld_reg <= al_ld;
        end
    end

    // Registered bus request fields, launched from IDLE and retired on ack/timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_req_out    <= 1'b0;
            MEM_Addr_out   <= '0;
            MEM_memwr_out  <= 1'b0;
            MEM_bwe_out    <= '0;
            MEM_STData_out <= '0;
        end else if (start) begin
            MEM_req_out    <= 1'b1;
            MEM_Addr_out   <= {MEM_ALUOut_in[31:OFS_W], OFS_W'(0)};
            MEM_memwr_out  <= MEM_memwr_in;
            MEM_bwe_out    <= al_bwe;
            MEM_STData_out <= al_st;
        end else if ((state == MEM_ST_REQ) && (next_state != MEM_ST_REQ)) begin
            MEM_req_out   <= 1'b0;
            MEM_memwr_out <= 1'b0;
            MEM_bwe_out   <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench: two instances (32/64-bit bus, TIMEOUT=4)
// share control stimulus and are compared every cycle against a transaction model.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memop, memwr, ack, rw;
    logic [6:0]  mtype;
    logic [31:0] alu, std;
    logic [4:0]  rd;
    logic [31:0] ld32;
    logic [63:0] ld64;

    logic        q32_req, q32_memwr, q32_stall, q32_rw, q32_adel, q32_ades, q32_buserr;
    logic [31:0] q32_addr, q32_st, q32_mux;
    logic [3:0]  q32_bwe;
    logic [4:0]  q32_rd;
    logic        q64_req, q64_memwr, q64_stall, q64_rw, q64_adel, q64_ades, q64_buserr;
    logic [31:0] q64_addr, q64_mux;
    logic [63:0] q64_st;
    logic [7:0]  q64_bwe;
    logic [4:0]  q64_rd;

    int checks = 0;
    int errors = 0;

    // Expected values published by the driver for the compare process
    logic        cmp_en = 1'b0;
    logic        e_stall, e_req, e_adel, e_ades, e_buserr, e_memwr, e_rw, e_chk_rw, e_chk_mux;
    logic [31:0] e_addr, e_mux32, e_mux64;
    logic [3:0]  e_bwe32;
    logic [7:0]  e_bwe64;
    logic [63:0] e_st32, e_st64;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut32 (
        .clk(clk), .rst(rst), .MEM_memop_in(memop), .MEM_memwr_in(memwr),
        .MEM_memop_type_in(mtype), .MEM_ALUOut_in(alu), .MEM_STData_in(std),
        .MEM_inst_rd_in(rd), .MEM_RegWrite_in(rw), .MEM_ack_in(ack), .MEM_LDData_in(ld32),
        .MEM_req_out(q32_req), .MEM_Addr_out(q32_addr), .MEM_memwr_out(q32_memwr),
        .MEM_bwe_out(q32_bwe), .MEM_STData_out(q32_st), .MEM_stall_out(q32_stall),
        .MEM_MUXOut_out(q32_mux), .MEM_inst_rd_out(q32_rd), .MEM_RegWrite_out(q32_rw),
        .MEM_adel_out(q32_adel), .MEM_ades_out(q32_ades), .MEM_buserr_out(q32_buserr)
    );

    mem_access_unit #(.DATA_W(64), .TIMEOUT(TO), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .MEM_memop_in(memop), .MEM_memwr_in(memwr),
        .MEM_memop_type_in(mtype), .MEM_ALUOut_in(alu), .MEM_STData_in(std),
        .MEM_inst_rd_in(rd), .MEM_RegWrite_in(rw), .MEM_ack_in(ack), .MEM_LDData_in(ld64),
        .MEM_req_out(q64_req), .MEM_Addr_out(q64_addr), .MEM_memwr_out(q64_memwr),
        .MEM_bwe_out(q64_bwe), .MEM_STData_out(q64_st), .MEM_stall_out(q64_stall),
        .MEM_MUXOut_out(q64_mux), .MEM_inst_rd_out(q64_rd), .MEM_RegWrite_out(q64_rw),
        .MEM_adel_out(q64_adel), .MEM_ades_out(q64_ades), .MEM_buserr_out(q64_buserr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [6:0] t);
        if (t == 7'd1 || t == 7'd2) return 1;
        if (t == 7'd3 || t == 7'd4) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [6:0] t, input logic [31:0] a);
        return (a % size_of(t)) != 0;
    endfunction

    function automatic logic [31:0] ld_model(input logic [6:0] t, input logic [31:0] a,
                                             input logic [63:0] bus, input int lanes);
        int sz = size_of(t);
        int ofs = int'(a % lanes);
        logic [63:0] v;
        logic [31:0] r;
        ofs = ofs - (ofs % sz);
        v = bus >> (8 * ofs);
        if (sz == 1) begin
            r = {24'd0, v[7:0]};
            if ((t == 7'd1) && v[7]) r[31:8] = '1;
        end else if (sz == 2) begin
            r = {16'd0, v[15:0]};
            if ((t == 7'd3) && v[15]) r[31:16] = '1;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    function automatic logic [7:0] bwe_model(input logic [6:0] t, input logic [31:0] a,
                                             input int lanes, input logic wr);
        int sz = size_of(t);
        int ofs = int'(a % lanes);
        if (!wr) return 8'd0;
        ofs = ofs - (ofs % sz);
        return 8'(((1 << sz) - 1) << ofs);
    endfunction

    function automatic logic [63:0] st_model(input logic [6:0] t, input logic [31:0] d, input int lanes);
        int sz = size_of(t);
        logic [63:0] m = (sz == 4) ? 64'hFFFF_FFFF : ((sz == 2) ? 64'hFFFF : 64'hFF);
        logic [63:0] r = '0;
        for (int i = 0; i < lanes; i += sz) r |= (64'(d) & m) << (8 * i);
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall32", 64'(q32_stall), 64'(e_stall));
            chk("stall64", 64'(q64_stall), 64'(e_stall));
            chk("req32", 64'(q32_req), 64'(e_req));
            chk("req64", 64'(q64_req), 64'(e_req));
            chk("adel32", 64'(q32_adel), 64'(e_adel));
            chk("adel64", 64'(q64_adel), 64'(e_adel));
            chk("ades32", 64'(q32_ades), 64'(e_ades));
            chk("ades64", 64'(q64_ades), 64'(e_ades));
            chk("buserr32", 64'(q32_buserr), 64'(e_buserr));
            chk("buserr64", 64'(q64_buserr), 64'(e_buserr));
            chk("rd32", 64'(q32_rd), 64'(e_rd));
            chk("rd64", 64'(q64_rd), 64'(e_rd));
            if (e_req) begin
                chk("addr32", 64'(q32_addr), 64'({e_addr[31:2], 2'b00}));
                chk("addr64", 64'(q64_addr), 64'({e_addr[31:3], 3'b000}));
                chk("memwr32", 64'(q32_memwr), 64'(e_memwr));
                chk("memwr64", 64'(q64_memwr), 64'(e_memwr));
                chk("bwe32", 64'(q32_bwe), 64'(e_bwe32));
                chk("bwe64", 64'(q64_bwe), 64'(e_bwe64));
                if (e_memwr) begin
                    chk("stdata32", 64'(q32_st), e_st32);
                    chk("stdata64", q64_st, e_st64);
                end
            end
            if (e_chk_rw) begin
                chk("regwrite32", 64'(q32_rw), 64'(e_rw));
                chk("regwrite64", 64'(q64_rw), 64'(e_rw));
            end
            if (e_chk_mux) begin
                chk("muxout32", 64'(q32_mux), 64'(e_mux32));
                chk("muxout64", 64'(q64_mux), 64'(e_mux64));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_stall = 1'b0; e_req = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_buserr = 1'b0;
        e_chk_rw = 1'b0; e_chk_mux = 1'b0;
    endtask

    // One instruction through the MEM stage; ackc = REQ cycle carrying ack (>TO means never)
    task automatic run_txn(input logic m, input logic wr, input logic [6:0] t,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                           input logic regw, input int ackc, input logic [31:0] bus32,
                           input logic [63:0] bus64, input int rst_at);
        int  n;
        bit  tout;
        bit  aborted;
        logic late_ack;
        memop = m; memwr = wr; mtype = t; alu = a; std = d; rd = r; rw = regw;
        e_rd = r; e_addr = a; e_memwr = wr;
        e_bwe32 = 4'(bwe_model(t, a, 4, wr));
        e_bwe64 = bwe_model(t, a, 8, wr);
        e_st32 = st_model(t, d, 4);
        e_st64 = st_model(t, d, 8);
        idle_exp();
        if (!m) begin
            ack = 1'($urandom);
            e_chk_rw = 1'b1; e_rw = regw;
            e_chk_mux = 1'b1; e_mux32 = a; e_mux64 = a;
            step();
            return;
        end
        if (misaligned(t, a)) begin
            ack = 1'b0;
            e_adel = !wr; e_ades = wr;
            e_chk_rw = 1'b1; e_rw = 1'b0;
            step();
            return;
        end
        tout = (ackc > int'(TO));
        n = tout ? int'(TO) : ackc;
        late_ack = 1'b0;
        for (int att = 0; att < 2; att++) begin
            aborted = 1'b0;
            idle_exp();
            ack = late_ack;
            e_stall = 1'b1;
            step();
            for (int c = 1; c <= n; c++) begin
                if ((att == 0) && (c == rst_at)) begin
                    rst = 1'b1; ack = 1'b1;
                    idle_exp();
                    step();
                    rst = 1'b0; ack = 1'b0;
                    late_ack = 1'($urandom);
                    aborted = 1'b1;
                    break;
                end
                ack = (c == ackc);
                ld32 = (c == ackc) ? bus32 : $urandom;
                ld64 = (c == ackc) ? bus64 : {$urandom, $urandom};
                idle_exp();
                e_req = 1'b1; e_stall = 1'b1;
                step();
            end
            if (!aborted) break;
        end
        ack = 1'b0;
        ld32 = $urandom; ld64 = {$urandom, $urandom};
        idle_exp();
        e_buserr = tout;
        e_chk_rw = 1'b1; e_rw = tout ? 1'b0 : regw;
        e_chk_mux = 1'b1;
        e_mux32 = tout ? 32'd0 : (wr ? a : ld_model(t, a, {32'd0, bus32}, 4));
        e_mux64 = tout ? 32'd0 : (wr ? a : ld_model(t, a, bus64, 8));
        step();
    endtask

    initial begin
        int ackc, rst_at, sel, nmax;
        logic [6:0] t;
        rst = 1'b1; memop = 1'b0; memwr = 1'b0; mtype = '0; alu = '0; std = '0;
        rd = '0; rw = 1'b0; ack = 1'b0; ld32 = '0; ld64 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req32", 64'(q32_req), 64'd0);
        chk("rst_req64", 64'(q64_req), 64'd0);
        chk("rst_stall", 64'(q32_stall), 64'd0);
        chk("rst_bwe64", 64'(q64_bwe), 64'd0);
        chk("rst_memwr", 64'(q32_memwr), 64'd0);
        chk("rst_buserr", 64'(q64_buserr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pin the model to hand-computed values
        chk("pin_lb", 64'(ld_model(7'd1, 32'h103, 64'h80FF_0000, 4)), 64'hFFFF_FF80);
        chk("pin_lhu64", 64'(ld_model(7'd4, 32'h106, 64'hBEEF_0000_0000_0000, 8)), 64'h0000_BEEF);
        chk("pin_sh_bwe", 64'(bwe_model(7'd3, 32'h202, 4, 1'b1)), 64'h0C);
        chk("pin_sh_data", st_model(7'd3, 32'h1234_ABCD, 4), 64'hABCD_ABCD);
        chk("pin_sb64_bwe", 64'(bwe_model(7'd1, 32'h105, 8, 1'b1)), 64'h20);
        chk("pin_sw64_bwe", 64'(bwe_model(7'd5, 32'h104, 8, 1'b1)), 64'hF0);
        chk("pin_lw_mis", 64'(misaligned(7'd5, 32'h101)), 64'd1);
        chk("pin_ld_load_bwe", 64'(bwe_model(7'd5, 32'h100, 8, 1'b0)), 64'd0);

        cmp_en = 1'b1;
        // Directed scenarios
        run_txn(1'b1, 1'b0, 7'd1, 32'h103, 32'h0, 5'd3, 1'b1, 3, 32'h80FF_0000, 64'h0000_0000_80FF_0000, 0);
        run_txn(1'b1, 1'b1, 7'd3, 32'h202, 32'h1234_ABCD, 5'd4, 1'b0, 1, 32'h0, 64'h0, 0);
        run_txn(1'b1, 1'b0, 7'd5, 32'h101, 32'h0, 5'd5, 1'b1, 1, 32'h0, 64'h0, 0);
        run_txn(1'b1, 1'b0, 7'd5, 32'h300, 32'h0, 5'd6, 1'b1, 99, 32'h0, 64'h0, 0);
        run_txn(1'b1, 1'b0, 7'd4, 32'h106, 32'h0, 5'd7, 1'b1, 1, 32'h5555_AAAA, 64'hBEEF_0000_0000_0000, 0);
        run_txn(1'b1, 1'b1, 7'd1, 32'h105, 32'h0000_00A5, 5'd8, 1'b0, 2, 32'h0, 64'h0, 0);
        run_txn(1'b1, 1'b0, 7'd1, 32'h100, 32'h0, 5'd9, 1'b1, 3, 32'h0000_007F, 64'h7F, 2);
        run_txn(1'b0, 1'b0, 7'd0, 32'hDEAD_BEEF, 32'h0, 5'd10, 1'b1, 1, 32'h0, 64'h0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 7));
            t = (sel < 6) ? 7'(sel) : 7'($urandom_range(6, 127));
            ackc = int'($urandom_range(1, 6));
            nmax = (ackc > int'(TO)) ? int'(TO) : ackc;
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, nmax)) : 0;
            run_txn(($urandom_range(0, 99) < 85), 1'($urandom), t, $urandom, $urandom,
                    5'($urandom), 1'($urandom), ackc, $urandom, {$urandom, $urandom}, rst_at);
        end
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
